// File: rtl/product_monitor_pkg.sv
// Shared definitions for product_monitor: FSM state encoding and the
// latency-counter width helper.
package product_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  // Bits needed to count from 0 up to and including max_cycles.
  function automatic int cw_of(input int max_cycles);
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/product_monitor_latency_capture.sv
// One channel of the monitor: remembers whether this channel has completed
// during the current run, and at which counter value and with which product.
// The *_next values are exposed so the top can build a verdict on the same
// edge that a late completion is captured.
module latency_capture #(
  parameter int PW = 32,
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  input  logic          done,
  input  logic [PW-1:0] product,
  input  logic [CW-1:0] counter,
  output logic          got,
  output logic          got_next,
  output logic [CW-1:0] latency_next,
  output logic [PW-1:0] capture_next
);

  logic [CW-1:0] latency;
  logic [PW-1:0] capture;

  // First done seen while enabled wins; later dones are ignored until cleared.
  always_comb begin
    got_next     = got;
    latency_next = latency;
    capture_next = capture;
    if (clear) begin
      got_next = 1'b0;
    end else if (enable && done && !got) begin
      got_next     = 1'b1;
      latency_next = counter;
      capture_next = product;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      got     <= 1'b0;
      latency <= '0;
      capture <= '0;
    end else begin
      got     <= got_next;
      latency <= latency_next;
      capture <= capture_next;
    end
  end

endmodule

// File: rtl/product_monitor.sv
// Watches two multipliers started by the same trigger and reports whether
// their products agree, whether their latencies agree, and whether the run
// timed out. Optional build macro PRODUCT_MONITOR_STICKY_EN makes the three
// verdict flags accumulate across runs until reset.
//
// Handshake: start is a level sampled only in IDLE; productDoneA/B are
// sampled only in RUN (first assertion per channel counts); checkValid is a
// one-cycle strobe marking the cycle the verdict outputs take new values.
module product_monitor
  import product_monitor_pkg::*;
#(
  parameter int  WIDTH      = 16,
  parameter int  MAX_CYCLES = 64,
  localparam int CW         = cw_of(MAX_CYCLES)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] productA,
  input  logic [2*WIDTH-1:0] productB,
  input  logic               productDoneA,
  input  logic               productDoneB,
  output logic               busy,
  output logic               checkValid,
  output logic               mismatch,
  output logic               timingLeak,
  output logic               timeout,
  output logic [CW-1:0]      latencyA,
  output logic [CW-1:0]      latencyB,
  output state_t             dbg_state
);

  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_CYCLES);

  state_t state, state_next;
  logic [CW-1:0] counter;
  logic clear, enable, report_load;
  logic got_a, got_b, got_a_next, got_b_next;
  logic [CW-1:0] lat_a_next, lat_b_next;
  logic [2*WIDTH-1:0] cap_a_next, cap_b_next;
  logic both_next, mis_new, leak_new, to_new;

  assign clear       = (state == IDLE) && start;
  assign enable      = (state == RUN);
  assign report_load = (state == RUN) && (state_next == REPORT);
  assign busy        = (state != IDLE);
  assign checkValid  = (state == REPORT);
  assign dbg_state   = state;

  latency_capture #(.PW(2*WIDTH), .CW(CW)) u_cap_a (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable),
    .done(productDoneA), .product(productA), .counter(counter),
    .got(got_a), .got_next(got_a_next),
    .latency_next(lat_a_next), .capture_next(cap_a_next)
  );

  latency_capture #(.PW(2*WIDTH), .CW(CW)) u_cap_b (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable),
    .done(productDoneB), .product(productB), .counter(counter),
    .got(got_b), .got_next(got_b_next),
    .latency_next(lat_b_next), .capture_next(cap_b_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state: RUN ends the cycle after both channels are in, or at the
  // saturated counter if either is still missing.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if ((got_a && got_b) || (counter == CNT_MAX)) state_next = REPORT;
      REPORT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latency counter: 1 on the accepted start, then counts up saturating.
  always_ff @(posedge clk) begin
    if (rst) begin
      counter <= '0;
    end else if (clear) begin
      counter <= CW'(1);
    end else if (enable && (counter != CNT_MAX)) begin
      counter <= counter + CW'(1);
    end
  end

  // Verdict computed from the post-edge channel view, so a completion caught
  // on the final timeout cycle still counts as a completion.
  always_comb begin
    both_next = got_a_next && got_b_next;
    mis_new   = both_next && (cap_a_next != cap_b_next);
    leak_new  = both_next ? (lat_a_next != lat_b_next) : (got_a_next ^ got_b_next);
    to_new    = !both_next;
  end

  // Verdict and latency outputs load on entry to REPORT and hold until the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch   <= 1'b0;
      timingLeak <= 1'b0;
      timeout    <= 1'b0;
      latencyA   <= '0;
      latencyB   <= '0;
    end else if (report_load) begin
`ifdef PRODUCT_MONITOR_STICKY_EN
      mismatch   <= mismatch   | mis_new;
      timingLeak <= timingLeak | leak_new;
      timeout    <= timeout    | to_new;
`else
      mismatch   <= mis_new;
      timingLeak <= leak_new;
      timeout    <= to_new;
`endif
      latencyA   <= got_a_next ? lat_a_next : '0;
      latencyB   <= got_b_next ? lat_b_next : '0;
    end
  end

endmodule

// File: tb/tb_product_monitor.sv
// Directed bench for product_monitor (WIDTH=16, MAX_CYCLES=64).
module tb_product_monitor;
  import product_monitor_pkg::*;

  localparam int W  = 16;
  localparam int MC = 64;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2*W-1:0] productA, productB;
  logic          productDoneA, productDoneB;
  logic          busy, checkValid, mismatch, timingLeak, timeout;
  logic [CW-1:0] latencyA, latencyB;
  state_t        dbg_state;

  int vectors = 0;
  int miscompares = 0;
  logic acc_mis = 1'b0, acc_leak = 1'b0, acc_to = 1'b0;

  product_monitor #(.WIDTH(W), .MAX_CYCLES(MC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .productA(productA), .productB(productB),
    .productDoneA(productDoneA), .productDoneB(productDoneB),
    .busy(busy), .checkValid(checkValid), .mismatch(mismatch),
    .timingLeak(timingLeak), .timeout(timeout),
    .latencyA(latencyA), .latencyB(latencyB), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Advance one edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic mis, input logic leak,
                            input logic to, input logic [CW-1:0] la, input logic [CW-1:0] lb);
    vectors++;
    if ({mismatch, timingLeak, timeout} !== {mis, leak, to}) begin
      miscompares++;
      $display("FAIL %s flags: got mis/leak/to=%b%b%b want %b%b%b", name,
               mismatch, timingLeak, timeout, mis, leak, to);
    end
    vectors++;
    if (latencyA !== la || latencyB !== lb) begin
      miscompares++;
      $display("FAIL %s latency: got A=%0d B=%0d want A=%0d B=%0d", name,
               latencyA, latencyB, la, lb);
    end
  endtask

  // One run: lat 0 means the channel never completes. pre_done pulses both
  // dones on the start edge; hold_start keeps start high during RUN.
  task automatic run(input string name, input int lat_a, input int lat_b,
                     input logic [2*W-1:0] pa, input logic [2*W-1:0] pb,
                     input bit pre_done, input bit hold_start);
    bit ga, gb, both;
    logic em, el, et;
    logic [CW-1:0] ela, elb;
    int exp_rep, rep, mx;
    ga = (lat_a >= 1) && (lat_a <= MC);
    gb = (lat_b >= 1) && (lat_b <= MC);
    both = ga && gb;
    mx = (lat_a > lat_b) ? lat_a : lat_b;
    exp_rep = (both && mx < MC) ? mx + 1 : MC;
    em = both && (pa != pb);
    el = both ? (lat_a != lat_b) : (ga ^ gb);
    et = !both;
    ela = ga ? CW'(lat_a) : '0;
    elb = gb ? CW'(lat_b) : '0;
    acc_mis = acc_mis | em; acc_leak = acc_leak | el; acc_to = acc_to | et;
`ifdef PRODUCT_MONITOR_STICKY_EN
    em = acc_mis; el = acc_leak; et = acc_to;
`endif
    productA = pa; productB = pb;
    start = 1'b1;
    productDoneA = pre_done; productDoneB = pre_done;
    step();
    start = hold_start;
    rep = -1;
    for (int c = 1; c <= 80; c++) begin
      productDoneA = (c == lat_a);
      productDoneB = (c == lat_b);
      step();
      if (checkValid) begin
        rep = c;
        break;
      end
    end
    productDoneA = 1'b0; productDoneB = 1'b0;
    start = 1'b0;
    vectors++;
    if (rep != exp_rep) begin
      miscompares++;
      $display("FAIL %s report_cycle: got %0d want %0d", name, rep, exp_rep);
    end
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s busy_in_report: got %b want 1", name, busy);
    end
    check_outs(name, em, el, et, ela, elb);
    step();
    vectors++;
    if ({checkValid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL %s after_report cv/busy: got %b%b want 00", name, checkValid, busy);
    end
    check_outs({name, "_hold"}, em, el, et, ela, elb);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; productDoneA = 1'b0; productDoneB = 1'b0;
    productA = '0; productB = '0;
    step(); step();
    rst = 1'b0;
    acc_mis = 1'b0; acc_leak = 1'b0; acc_to = 1'b0;
    vectors++;
    if ({busy, checkValid} !== 2'b00 || dbg_state !== IDLE) begin
      miscompares++;
      $display("FAIL reset_ctrl: got busy/cv=%b%b state=%0d want 00 state=0", busy, checkValid, dbg_state);
    end
    check_outs("reset", 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_idle_done();
    productA = 32'h1234; productDoneA = 1'b1; productDoneB = 1'b1;
    step(); step();
    productDoneA = 1'b0; productDoneB = 1'b0;
    vectors++;
    if ({busy, checkValid} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_done: got busy/cv=%b%b want 00", busy, checkValid);
    end
  endtask

  task automatic test_mid_reset();
    productA = 32'h55; productB = 32'h66;
    start = 1'b1; step(); start = 1'b0;
    productDoneA = 1'b1; step(); productDoneA = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    acc_mis = 1'b0; acc_leak = 1'b0; acc_to = 1'b0;
    vectors++;
    if ({busy, checkValid} !== 2'b00) begin
      miscompares++;
      $display("FAIL mid_reset_ctrl: got busy/cv=%b%b want 00", busy, checkValid);
    end
    check_outs("mid_reset", 1'b0, 1'b0, 1'b0, '0, '0);
    run("after_reset", 4, 6, 32'h10, 32'h10, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    run("equal_17", 17, 17, 32'h0000_1E0F, 32'h0000_1E0F, 1'b0, 1'b0);
    run("leak_5_17", 5, 17, 32'h0000_0042, 32'h0000_0042, 1'b0, 1'b0);
    run("mismatch", 9, 9, 32'd6, 32'd7, 1'b0, 1'b0);
    run("clean", 9, 9, 32'd8, 32'd8, 1'b0, 1'b0);
    run("timeout_b", 20, 0, 32'd3, 32'd3, 1'b0, 1'b0);
    run("timeout_both", 0, 0, 32'd1, 32'd2, 1'b0, 1'b0);
    test_reset();
    run("lat_one", 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run("pre_done", 3, 3, 32'hA5A5, 32'hA5A5, 1'b1, 1'b0);
    run("start_held", 7, 7, 32'h77, 32'h77, 1'b0, 1'b1);
    run("last_cycle", 10, 64, 32'h9, 32'h9, 1'b0, 1'b0);
    test_idle_done();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/product_monitor.md
PRODUCT_MONITOR -- requirements
Module: product_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand width; products are 2*WIDTH bits.
REQ-002 SHALL have parameter MAX_CYCLES, default 64, the timeout limit in cycles after start.
REQ-003 SHALL have derived localparam CW = $clog2(MAX_CYCLES+1), the latency counter width.
REQ-004 SHALL have port clk  input  1  single clock, rising-edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  run trigger, same signal that drives both monitored multipliers.
REQ-007 SHALL have port productA / productB  input  2*WIDTH  product of channel A / channel B.
REQ-008 SHALL have port productDoneA / productDoneB  input  1  completion flag of channel A / channel B.
REQ-009 SHALL have port busy  output  1  high while a run is being monitored.
REQ-010 SHALL have port checkValid  output  1  one-cycle pulse when the verdict outputs update.
REQ-011 SHALL have port mismatch  output  1  captured products differ.
REQ-012 SHALL have port timingLeak  output  1  channel latencies differ, or only one channel completed.
REQ-013 SHALL have port timeout  output  1  run ended by MAX_CYCLES rather than by both completions.
REQ-014 SHALL have port latencyA / latencyB  output  CW  cycles from start to the first done of each channel.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, REPORT.
REQ-016 In IDLE, start=1 SHALL move the FSM to RUN, load the counter with 1, and clear the per-channel got flags.
REQ-017 In RUN, the counter SHALL increment every cycle and saturate at MAX_CYCLES.
REQ-018 In RUN, the first cycle with productDoneX=1 and gotX=0 SHALL capture latencyX=counter and the product of that channel, and set gotX.
REQ-019 A done asserted in the same cycle start is accepted SHALL be ignored; done-after-start of 1 cycle SHALL give latency=1.
REQ-020 Both channels done in the same cycle SHALL both be captured in that cycle.
REQ-021 RUN SHALL move to REPORT on the cycle after both got flags are set, or when counter==MAX_CYCLES with either flag still clear.
REQ-022 REPORT SHALL last exactly 1 cycle with checkValid=1, then return to IDLE.
REQ-023 In REPORT, mismatch SHALL equal (capA != capB) when both channels completed, else 0.
REQ-024 In REPORT, timingLeak SHALL equal (latencyA != latencyB) when both channels completed, else 1 if exactly one completed, else 0.
REQ-025 In REPORT, timeout SHALL equal 1 if either channel did not complete.
REQ-026 latencyX of a channel that did not complete SHALL read 0.
REQ-027 Verdict and latency outputs SHALL hold their values from REPORT until the next REPORT.
REQ-028 busy SHALL be 1 in RUN and REPORT.
REQ-029 start SHALL be ignored in RUN and REPORT; no restart and no counter reload.
REQ-030 productDone pulses outside RUN SHALL have no effect.

Reset
REQ-031 rst=1 SHALL, at any state including mid-run, force IDLE and zero busy, checkValid, mismatch, timingLeak, timeout, latencyA, latencyB, the counter, the captured products and the got flags on the next edge.

Configuration
REQ-032 Macro PRODUCT_MONITOR_STICKY_EN, when defined, SHALL make mismatch, timingLeak and timeout OR-accumulate across REPORTs, cleared only by rst; latencies still overwrite each REPORT.
REQ-033 Without PRODUCT_MONITOR_STICKY_EN, each REPORT SHALL overwrite all verdicts.

Structure
REQ-034 Package product_monitor_pkg SHALL hold the FSM state encoding (IDLE=0, RUN=1, REPORT=2) and the CW width function.
REQ-035 Sub-module latency_capture SHALL implement one channel's got flag, latency register and product register, instantiated twice.

Verification
REQ-036 Scenario: start, both done at cycle 17, products 0x0000_1E0F each -> checkValid at cycle 18, mismatch=0, timingLeak=0, latencyA=latencyB=17.
REQ-037 Scenario: doneA at cycle 5, doneB at cycle 17 -> timingLeak=1, latencyA=5, latencyB=17, timeout=0.
REQ-038 Scenario: same latencies, productA=6, productB=7 -> mismatch=1, timingLeak=0.
REQ-039 Scenario: doneB never asserted, MAX_CYCLES=64 -> REPORT at counter 64, timeout=1, timingLeak=1, latencyB=0.
REQ-040 Scenario: rst at cycle 8 of a run, then start again -> all outputs 0 after reset; the fresh run reports correct latencies.
REQ-041 Scenario: sticky build, mismatch run then clean run -> mismatch stays 1; non-sticky build -> mismatch returns to 0.
